// File: rtl/ddr_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// ddr_req_arbiter_if
// Bundles every client request, the downstream DDR cache handshake and the
// arbiter status outputs so they travel as one port.
//
//   slave  modport : the arbiter (samples requests/dn_done, drives dn_*,
//                    acks, busy, timeout_err, state)
//   master modport : the requesters plus the downstream cache side
//
// Signals:
//   init_calib_complete      DDR calibrated; arbiter grants only while high
//   isa_req/isa_addr/isa_len instruction burst read request (pulse + data)
//   drd_req/drd_addr         data read request
//   dwr_req/dwr_addr         data store request
//   jmp_req/jmp_addr         jump-address fetch request
//   dn_isa/dn_drd/dn_dwr/dn_jmp  one-hot level request to the DDR cache
//   dn_addr/dn_len           address/length of the granted request
//   dn_done                  completion pulse from downstream
//   isa_ack/drd_ack/dwr_ack/jmp_ack  completion pulse to each requester
//   busy, timeout_err, state arbiter status
// ---------------------------------------------------------------------------
interface ddr_req_arbiter_if #(
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int LEN_WIDTH      = 10
);
    logic                      init_calib_complete;
    logic                      isa_req;
    logic [DDR_ADDR_WIDTH-1:0] isa_addr;
    logic [LEN_WIDTH-1:0]      isa_len;
    logic                      drd_req;
    logic [DDR_ADDR_WIDTH-1:0] drd_addr;
    logic                      dwr_req;
    logic [DDR_ADDR_WIDTH-1:0] dwr_addr;
    logic                      jmp_req;
    logic [DDR_ADDR_WIDTH-1:0] jmp_addr;
    logic                      dn_isa;
    logic                      dn_drd;
    logic                      dn_dwr;
    logic                      dn_jmp;
    logic [DDR_ADDR_WIDTH-1:0] dn_addr;
    logic [LEN_WIDTH-1:0]      dn_len;
    logic                      dn_done;
    logic                      isa_ack;
    logic                      drd_ack;
    logic                      dwr_ack;
    logic                      jmp_ack;
    logic                      busy;
    logic                      timeout_err;
    logic [1:0]                state;

    modport slave (
        input  init_calib_complete,
        input  isa_req, isa_addr, isa_len,
        input  drd_req, drd_addr,
        input  dwr_req, dwr_addr,
        input  jmp_req, jmp_addr,
        input  dn_done,
        output dn_isa, dn_drd, dn_dwr, dn_jmp, dn_addr, dn_len,
        output isa_ack, drd_ack, dwr_ack, jmp_ack,
        output busy, timeout_err, state
    );

    modport master (
        output init_calib_complete,
        output isa_req, isa_addr, isa_len,
        output drd_req, drd_addr,
        output dwr_req, dwr_addr,
        output jmp_req, jmp_addr,
        output dn_done,
        input  dn_isa, dn_drd, dn_dwr, dn_jmp, dn_addr, dn_len,
        input  isa_ack, drd_ack, dwr_ack, jmp_ack,
        input  busy, timeout_err, state
    );
endinterface

// File: rtl/ddr_req_arbiter.sv
// ---------------------------------------------------------------------------
// ddr_req_arbiter
// Collects one-cycle request pulses from four clients (ISA fetch, data read,
// data store, jump fetch), holds each as a pending entry with its address,
// and serves them one at a time to the DDR cache interface with fixed
// priority dwr > jmp > drd > isa. A watchdog abandons a grant that never
// sees dn_done.
//
// Ports:
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous active-high reset
//   bus  : ddr_req_arbiter_if.slave (requests, dn_* handshake, acks, status)
// ---------------------------------------------------------------------------
module ddr_req_arbiter #(
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int LEN_WIDTH      = 10,
    parameter int DATA_BURST_LEN = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    ddr_req_arbiter_if.slave  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Client slot order used by every vector below: 0=isa 1=drd 2=dwr 3=jmp
    localparam int NUM_CLI = 4;
    localparam int CNT_W   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [NUM_CLI-1:0]        req_in;
    logic [DDR_ADDR_WIDTH-1:0] addr_in  [NUM_CLI];
    logic [NUM_CLI-1:0]        pend_q;
    logic [DDR_ADDR_WIDTH-1:0] lat_addr [NUM_CLI];
    logic [NUM_CLI-1:0]        clr_pend;
    logic [LEN_WIDTH-1:0]      isa_len_q;

    logic [1:0]                state_q,   state_d;
    logic [NUM_CLI-1:0]        win_q,     win_d;
    logic [NUM_CLI-1:0]        dn_q,      dn_d;
    logic [DDR_ADDR_WIDTH-1:0] dn_addr_q, dn_addr_d;
    logic [LEN_WIDTH-1:0]      dn_len_q,  dn_len_d;
    logic [NUM_CLI-1:0]        ack_q,     ack_d;
    logic                      tmo_q,     tmo_d;
    logic [CNT_W-1:0]          cnt_q,     cnt_d;

    logic [NUM_CLI-1:0]        pick;
    logic [DDR_ADDR_WIDTH-1:0] pick_addr;
    logic [LEN_WIDTH-1:0]      pick_len;
    logic                      timeout_hit;

    assign req_in     = {bus.jmp_req, bus.dwr_req, bus.drd_req, bus.isa_req};
    assign addr_in[0] = bus.isa_addr;
    assign addr_in[1] = bus.drd_addr;
    assign addr_in[2] = bus.dwr_addr;
    assign addr_in[3] = bus.jmp_addr;

    assign timeout_hit = (state_q == ST_WAIT) && !bus.dn_done && (cnt_q == CNT_LAST);

    // The winner's entry is released on the DONE cycle (alongside its ack)
    // or when the watchdog fires.
    assign clr_pend = ((state_q == ST_DONE) || timeout_hit) ? win_q : '0;

    // Per-client pending entry. A new pulse is accepted when the slot is
    // free or is being released this very cycle, so a request landing on
    // its own ack cycle is not lost; otherwise repeats are dropped and the
    // first address is kept.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLI; gi++) begin : g_cli
            logic                      pend_r_q;
            logic [DDR_ADDR_WIDTH-1:0] addr_r_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    pend_r_q <= 1'b0;
                    addr_r_q <= '0;
                end else if (req_in[gi] && (!pend_r_q || clr_pend[gi])) begin
                    pend_r_q <= 1'b1;
                    addr_r_q <= addr_in[gi];
                end else if (clr_pend[gi]) begin
                    pend_r_q <= 1'b0;
                end
            end

            assign pend_q[gi]   = pend_r_q;
            assign lat_addr[gi] = addr_r_q;
        end
    endgenerate

    // Only ISA carries its own length; it follows the same acceptance rule.
    always_ff @(posedge clk) begin
        if (rst) begin
            isa_len_q <= '0;
        end else if (bus.isa_req && (!pend_q[0] || clr_pend[0])) begin
            isa_len_q <= bus.isa_len;
        end
    end

    // Fixed-priority pick: dwr > jmp > drd > isa.
    always_comb begin
        pick      = '0;
        pick_addr = '0;
        pick_len  = '0;
        if (pend_q[2]) begin
            pick      = 4'b0100;
            pick_addr = lat_addr[2];
            pick_len  = LEN_WIDTH'(DATA_BURST_LEN);
        end else if (pend_q[3]) begin
            pick      = 4'b1000;
            pick_addr = lat_addr[3];
            pick_len  = LEN_WIDTH'(1);
        end else if (pend_q[1]) begin
            pick      = 4'b0010;
            pick_addr = lat_addr[1];
            pick_len  = LEN_WIDTH'(DATA_BURST_LEN);
        end else if (pend_q[0]) begin
            pick      = 4'b0001;
            pick_addr = lat_addr[0];
            pick_len  = isa_len_q;
        end
    end

    // Grant outputs are loaded on the IDLE->GRANT edge so dn_* is already
    // up in the GRANT cycle and simply held through WAIT. Calibration is
    // only consulted in IDLE, so an in-flight transaction always finishes.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        dn_d      = dn_q;
        dn_addr_d = dn_addr_q;
        dn_len_d  = dn_len_q;
        ack_d     = '0;
        tmo_d     = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.init_calib_complete && (|pend_q)) begin
                    state_d   = ST_GRANT;
                    win_d     = pick;
                    dn_d      = pick;
                    dn_addr_d = pick_addr;
                    dn_len_d  = pick_len;
                    cnt_d     = '0;
                end
            end
            ST_GRANT: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (bus.dn_done) begin
                    state_d   = ST_DONE;
                    dn_d      = '0;
                    dn_addr_d = '0;
                    dn_len_d  = '0;
                    ack_d     = win_q;
                end else if (timeout_hit) begin
                    state_d   = ST_IDLE;
                    dn_d      = '0;
                    dn_addr_d = '0;
                    dn_len_d  = '0;
                    tmo_d     = 1'b1;
                    win_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                win_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            win_q     <= '0;
            dn_q      <= '0;
            dn_addr_q <= '0;
            dn_len_q  <= '0;
            ack_q     <= '0;
            tmo_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            dn_q      <= dn_d;
            dn_addr_q <= dn_addr_d;
            dn_len_q  <= dn_len_d;
            ack_q     <= ack_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.dn_isa      = dn_q[0];
    assign bus.dn_drd      = dn_q[1];
    assign bus.dn_dwr      = dn_q[2];
    assign bus.dn_jmp      = dn_q[3];
    assign bus.dn_addr     = dn_addr_q;
    assign bus.dn_len      = dn_len_q;
    assign bus.isa_ack     = ack_q[0];
    assign bus.drd_ack     = ack_q[1];
    assign bus.dwr_ack     = ack_q[2];
    assign bus.jmp_ack     = ack_q[3];
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.timeout_err = tmo_q;
    assign bus.state       = state_q;

endmodule

// File: doc/ddr_req_arbiter.md
DDR_REQ_ARBITER -- requirements
Module: ddr_req_arbiter

Interface
REQ-001 The block SHALL have parameter DDR_ADDR_WIDTH, default 28, giving the DDR byte/word address width.
REQ-002 The block SHALL have parameter LEN_WIDTH, default 10, giving the burst length width.
REQ-003 The block SHALL have parameter DATA_BURST_LEN, default 16, giving the burst length issued for data read/store.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 4096, giving the maximum cycles to wait for dn_done.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, as listed below.
- clk  in  1  ui clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- init_calib_complete  in  1  DDR ready; no grant while low.
- isa_req  in  1  one-cycle pulse: instruction burst read request.
- isa_addr  in  DDR_ADDR_WIDTH  ISA read address, sampled with isa_req.
- isa_len  in  LEN_WIDTH  ISA burst length, sampled with isa_req.
- drd_req / drd_addr  in  1 / DDR_ADDR_WIDTH  data read request pulse and address.
- dwr_req / dwr_addr  in  1 / DDR_ADDR_WIDTH  data store request pulse and address.
- jmp_req / jmp_addr  in  1 / DDR_ADDR_WIDTH  jump-address fetch request pulse and address.
- dn_isa, dn_drd, dn_dwr, dn_jmp  out  1 each  one-hot level request to DDR cache interface.
- dn_addr  out  DDR_ADDR_WIDTH  address of the granted request.
- dn_len  out  LEN_WIDTH  length of the granted request.
- dn_done  in  1  one-cycle completion pulse from downstream.
- isa_ack, drd_ack, dwr_ack, jmp_ack  out  1 each  one-cycle completion pulse to the requester.
- busy  out  1  high from grant to completion.
- timeout_err  out  1  one-cycle pulse when a grant times out.
- state  out  2  current FSM state encoding.

Function
REQ-006 Each client SHALL have a pending flag plus a latched address (and, for ISA, a latched length), set on the req pulse and cleared on that client's ack or on timeout.
REQ-007 A req pulse while the same client is already pending SHALL be ignored; the first address is kept.
REQ-008 FSM states SHALL be IDLE=0, GRANT=1, WAIT=2, DONE=3.
REQ-009 IDLE -> GRANT when init_calib_complete=1 and any pending flag is set; priority dwr > jmp > drd > isa.
REQ-010 In GRANT, the winner SHALL be registered, exactly one dn_* asserted, dn_addr/dn_len driven, then -> WAIT next cycle.
REQ-011 dn_len SHALL be isa_len for ISA, DATA_BURST_LEN for drd/dwr, and 1 for jmp.
REQ-012 In WAIT, dn_* SHALL be held stable until dn_done=1, then -> DONE; dn_done seen outside WAIT SHALL be ignored.
REQ-013 In DONE, dn_* SHALL be deasserted, the winner's ack pulsed for exactly one cycle and its pending flag cleared, then -> IDLE.
REQ-014 Request-to-dn_* latency from an idle arbiter with calibration complete SHALL be 2 cycles; dn_done-to-ack latency SHALL be 1 cycle.
REQ-015 A request pulse arriving in the same cycle as its own client's ack SHALL be kept as a new pending entry.
REQ-016 A wait counter SHALL clear on GRANT and increment in WAIT; on reaching TIMEOUT_CYCLES-1 without dn_done, the block SHALL pulse timeout_err, clear the winner's pending flag without ack, deassert dn_*, and -> IDLE.
REQ-017 busy SHALL be high in GRANT, WAIT and DONE.
REQ-018 If init_calib_complete falls while not IDLE, the current transaction SHALL complete; no new grant SHALL be made until it rises again.

Reset
REQ-019 While rst=1, all pending flags, latched addresses/lengths, dn_*, dn_addr, dn_len, acks, busy, timeout_err and the wait counter SHALL be 0, and state SHALL be IDLE; a transaction in flight SHALL be abandoned without ack.

Verification
REQ-020 Calib=1, isa_req with addr 0x100 and len 72 -> dn_isa=1, dn_addr=0x100, dn_len=72 two cycles later; dn_done -> isa_ack one cycle later, busy=0 after.
REQ-021 drd_req, dwr_req, jmp_req and isa_req in the same cycle -> grants in order dwr, jmp, drd, isa, each with the correct dn_len (16, 1, 16, len).
REQ-022 Calib=0 with dwr_req pending -> no dn_* asserted; on calib rising -> dn_dwr asserted 1 cycle later.
REQ-023 Grant with dn_done withheld for 4096 cycles -> timeout_err pulses once, no ack, state=IDLE, next pending request served.
REQ-024 rst asserted during WAIT -> all outputs 0 the next cycle; a dn_done after reset -> no ack.
REQ-025 isa_req repeated while ISA pending with a different addr -> the grant uses the first addr; isa_req in the isa_ack cycle -> a second ISA grant follows.
